// File: rtl/mul_share_ctrl_pkg.sv
// Shared definitions for the multiplier-sharing controller: data widths,
// FSM state encoding and a small index helper.
package mul_share_ctrl_pkg;

   localparam int OP_W  = 64;
   localparam int RES_W = 128;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   // Next round-robin index after idx, wrapping at n.
   function automatic int next_index(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/mul_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// above the pointer, wrapping, and returns it one-hot and encoded.
module rr_arbiter
   import mul_share_ctrl_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
)
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_id,
   output logic               grant_any
);

   int idx;

   // Walk the requesters starting at the pointer; the first hit wins.
   always_comb begin
      grant     = '0;
      grant_id  = '0;
      grant_any = 1'b0;
      idx       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (!grant_any && req[idx]) begin
            grant_any  = 1'b1;
            grant[idx] = 1'b1;
            grant_id   = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/mul_share_ctrl.sv
// Round-robin front end sharing one external 64x64 multiplier among NUM_REQ
// requesters. Define MUL_TIMEOUT_EN to abort stuck operations after TIMEOUT_CYCLES.
module mul_share_ctrl
   import mul_share_ctrl_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int ID_W           = 2,
   parameter int TIMEOUT_CYCLES = 64
)
(
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [OP_W*NUM_REQ-1:0] req_multiplier,
   input  logic [OP_W*NUM_REQ-1:0] req_multiplicand,
   output logic [NUM_REQ-1:0]      req_ack,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ID_W-1:0]         rsp_id,
   output logic [RES_W-1:0]        rsp_result,
   output logic                    rsp_err,
   output logic                    busy,
   output logic                    mul_op_start,
   output logic                    mul_op_clear,
   output logic [OP_W-1:0]         mul_multiplier,
   output logic [OP_W-1:0]         mul_multiplicand,
   input  logic                    mul_op_done,
   input  logic [RES_W-1:0]        mul_result
);

   state_t              state;
   logic [ID_W-1:0]     rr_ptr;
   logic [NUM_REQ-1:0]  grant;
   logic [ID_W-1:0]     grant_id;
   logic                grant_any;

   // The 8-bit timeout counter can only represent limits of 1..255.
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_out_of_range
   end

   rr_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .ID_W      (ID_W)
   ) u_arbiter (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_id  (grant_id),
      .grant_any (grant_any)
   );

`ifdef MUL_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] timer;
   logic       err_q;

   assign rsp_err = err_q;
`else
   assign rsp_err = 1'b0;
`endif

   // Controller FSM: grant in IDLE, one-cycle start pulse, wait for the
   // product, then hold the response with the multiplier cleared until accepted.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state            <= ST_IDLE;
         rr_ptr           <= '0;
         req_ack          <= '0;
         rsp_valid        <= 1'b0;
         rsp_id           <= '0;
         rsp_result       <= '0;
         busy             <= 1'b0;
         mul_op_start     <= 1'b0;
         mul_op_clear     <= 1'b0;
         mul_multiplier   <= '0;
         mul_multiplicand <= '0;
`ifdef MUL_TIMEOUT_EN
         timer            <= '0;
         err_q            <= 1'b0;
`endif
      end else begin
         req_ack <= '0;
         case (state)
            ST_IDLE: begin
               mul_op_start <= 1'b0;
               mul_op_clear <= 1'b0;
               if (grant_any) begin
                  mul_multiplier   <= req_multiplier[int'(grant_id)*OP_W +: OP_W];
                  mul_multiplicand <= req_multiplicand[int'(grant_id)*OP_W +: OP_W];
                  rsp_id           <= grant_id;
                  req_ack          <= grant;
                  rr_ptr           <= ID_W'(next_index(int'(grant_id), NUM_REQ));
                  mul_op_start     <= 1'b1;
                  busy             <= 1'b1;
                  state            <= ST_START;
               end
            end

            ST_START: begin
               mul_op_start <= 1'b0;
`ifdef MUL_TIMEOUT_EN
               timer        <= '0;
`endif
               state        <= ST_WAIT;
            end

            ST_WAIT: begin
               if (mul_op_done) begin
                  rsp_result   <= mul_result;
                  rsp_valid    <= 1'b1;
                  mul_op_clear <= 1'b1;
`ifdef MUL_TIMEOUT_EN
                  err_q        <= 1'b0;
`endif
                  state        <= ST_RESP;
               end
`ifdef MUL_TIMEOUT_EN
               // Clearing the multiplier from RESP is what aborts the stuck operation.
               else if (timer == TIMEOUT_LAST) begin
                  rsp_result   <= '0;
                  rsp_valid    <= 1'b1;
                  mul_op_clear <= 1'b1;
                  err_q        <= 1'b1;
                  state        <= ST_RESP;
               end else begin
                  timer <= timer + 8'd1;
               end
`endif
            end

            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid    <= 1'b0;
                  mul_op_clear <= 1'b0;
                  busy         <= 1'b0;
                  state        <= ST_IDLE;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Self-checking bench for mul_share_ctrl with a behavioural multiplier stub and
// a queue-free requester model; define MUL_TIMEOUT_EN to also exercise the abort path.
module tb_mul_share_ctrl;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;

   logic                    clk;
   logic                    reset_n;
   logic [NUM_REQ-1:0]      req_valid;
   logic [64*NUM_REQ-1:0]   req_multiplier;
   logic [64*NUM_REQ-1:0]   req_multiplicand;
   logic [NUM_REQ-1:0]      req_ack;
   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [ID_W-1:0]         rsp_id;
   logic [127:0]            rsp_result;
   logic                    rsp_err;
   logic                    busy;
   logic                    mul_op_start;
   logic                    mul_op_clear;
   logic [63:0]             mul_multiplier;
   logic [63:0]             mul_multiplicand;
   logic                    mul_op_done;
   logic [127:0]            mul_result;

   int check_count = 0;
   int error_count = 0;

   logic [63:0] op_a [NUM_REQ];
   logic [63:0] op_b [NUM_REQ];
   bit          pend [NUM_REQ];
   int          ptr;
   int          last_grant;
   bit          stub_mute;

   mul_share_ctrl #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT_CYCLES(64)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .req_valid        (req_valid),
      .req_multiplier   (req_multiplier),
      .req_multiplicand (req_multiplicand),
      .req_ack          (req_ack),
      .rsp_valid        (rsp_valid),
      .rsp_ready        (rsp_ready),
      .rsp_id           (rsp_id),
      .rsp_result       (rsp_result),
      .rsp_err          (rsp_err),
      .busy             (busy),
      .mul_op_start     (mul_op_start),
      .mul_op_clear     (mul_op_clear),
      .mul_multiplier   (mul_multiplier),
      .mul_multiplicand (mul_multiplicand),
      .mul_op_done      (mul_op_done),
      .mul_result       (mul_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Multiplier stub: start captures operands, done rises after a random
   // latency and is held until op_clear returns the unit to INIT.
   initial begin
      int          cnt;
      logic [63:0] sa, sb;
      cnt = 0; sa = '0; sb = '0;
      mul_op_done = 1'b0;
      mul_result  = '0;
      forever begin
         @(negedge clk);
         if (!reset_n || mul_op_clear) begin
            cnt = 0;
            mul_op_done = 1'b0;
            mul_result  = '0;
         end else if (mul_op_start) begin
            sa  = mul_multiplier;
            sb  = mul_multiplicand;
            cnt = $urandom_range(1, 6);
         end else if (cnt > 0 && !stub_mute) begin
            cnt--;
            if (cnt == 0) begin
               mul_op_done = 1'b1;
               mul_result  = {64'd0, sa} * {64'd0, sb};
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
      check_count++;
      if (got !== exp) begin
         error_count++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus();
      for (int i = 0; i < NUM_REQ; i++) begin
         req_valid[i]                 = pend[i];
         req_multiplier[i*64 +: 64]   = op_a[i];
         req_multiplicand[i*64 +: 64] = op_b[i];
      end
   endtask

   function automatic logic [63:0] rand_op();
      int sel;
      sel = $urandom_range(0, 7);
      if (sel == 0) return 64'd0;
      if (sel == 1) return '1;
      return {$urandom, $urandom};
   endfunction

   function automatic int onehot_index(input logic [NUM_REQ-1:0] v);
      for (int i = 0; i < NUM_REQ; i++)
         if (v[i]) return i;
      return -1;
   endfunction

   // One complete operation: expected winner from the model, ack, response,
   // optional backpressure, then acceptance.
   task automatic serve_one(input int stall, input bit ready_early, input bit keep_winner, input bit drop_en);
      int           exp_id;
      int           idx;
      bit           seen;
      logic [63:0]  exp_a;
      logic [127:0] exp_prod;
      exp_id = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (ptr + k) % NUM_REQ;
         if (exp_id < 0 && pend[idx]) exp_id = idx;
      end
      if (exp_id < 0) exp_id = 0;
      exp_a    = op_a[exp_id];
      exp_prod = {64'd0, op_a[exp_id]} * {64'd0, op_b[exp_id]};
      rsp_ready = ready_early;
      applyStimulus();

      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (req_ack != '0) seen = 1;
      end
      checkOutput("ack_seen", 128'(seen), 128'd1);
      checkOutput("ack_grant", 128'(req_ack), 128'(1) << exp_id);
      checkOutput("start_pulse", 128'(mul_op_start), 128'd1);
      checkOutput("busy_start", 128'(busy), 128'd1);
      last_grant = onehot_index(req_ack);

      ptr = (exp_id + 1) % NUM_REQ;
      if (keep_winner) begin
         op_a[exp_id] = rand_op();
         op_b[exp_id] = rand_op();
      end else begin
         pend[exp_id] = 0;
      end
      if (drop_en) begin
         for (int i = 0; i < NUM_REQ; i++)
            if (i != exp_id && pend[i] && $urandom_range(0, 3) == 0) pend[i] = 0;
      end
      applyStimulus();

      @(negedge clk);
      checkOutput("start_one_cycle", 128'(mul_op_start), 128'd0);
      seen = 0;
      for (int c = 0; c < 200 && !seen; c++) begin
         if (rsp_valid) seen = 1;
         else @(negedge clk);
      end
      checkOutput("rsp_seen", 128'(seen), 128'd1);
      checkOutput("rsp_id", 128'(rsp_id), 128'(exp_id));
      checkOutput("rsp_result", rsp_result, exp_prod);
      checkOutput("rsp_err", 128'(rsp_err), 128'd0);
      checkOutput("resp_clear", 128'(mul_op_clear), 128'd1);
      checkOutput("operand_hold", 128'(mul_multiplier), 128'(exp_a));

      if (!ready_early) begin
         for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            checkOutput("stall_valid", 128'(rsp_valid), 128'd1);
            checkOutput("stall_result", rsp_result, exp_prod);
            checkOutput("stall_no_ack", 128'(req_ack), 128'd0);
            checkOutput("stall_clear", 128'(mul_op_clear), 128'd1);
         end
         rsp_ready = 1'b1;
      end
      @(negedge clk);
      checkOutput("rsp_released", 128'(rsp_valid), 128'd0);
      checkOutput("idle_busy", 128'(busy), 128'd0);
      checkOutput("idle_clear", 128'(mul_op_clear), 128'd0);
      rsp_ready = 1'b0;
   endtask

   initial begin
      int rot [5];
      bit any;
      rot = '{0, 1, 2, 3, 0};
      reset_n = 1'b0;
      rsp_ready = 1'b0;
      stub_mute = 1'b0;
      ptr = 0;
      last_grant = -1;
      for (int i = 0; i < NUM_REQ; i++) begin
         pend[i] = 0; op_a[i] = '0; op_b[i] = '0;
      end
      applyStimulus();
      repeat (3) @(negedge clk);
      checkOutput("reset_ack", 128'(req_ack), 128'd0);
      checkOutput("reset_rsp_valid", 128'(rsp_valid), 128'd0);
      checkOutput("reset_busy", 128'(busy), 128'd0);
      checkOutput("reset_start_clear", 128'({mul_op_start, mul_op_clear, rsp_err}), 128'd0);
      checkOutput("reset_result", rsp_result, 128'd0);
      checkOutput("reset_operands", 128'({mul_multiplier, mul_multiplicand}), 128'd0);
      reset_n = 1'b1;
      @(negedge clk);

      $display("[TB] single requester");
      pend[0] = 1; op_a[0] = 64'd3; op_b[0] = 64'd5;
      serve_one(0, 0, 0, 0);

      $display("[TB] full-width operands");
      pend[2] = 1; op_a[2] = '1; op_b[2] = '1;
      serve_one(3, 1, 0, 0);

      $display("[TB] reset during WAIT");
      pend[1] = 1; op_a[1] = 64'd7; op_b[1] = 64'd9;
      applyStimulus();
      any = 0;
      for (int c = 0; c < 20 && !any; c++) begin
         @(negedge clk);
         if (req_ack != '0) any = 1;
      end
      checkOutput("mid_reset_ack", 128'(req_ack), 128'b0010);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("mid_reset_busy", 128'(busy), 128'd0);
      checkOutput("mid_reset_ctrl", 128'({req_ack, rsp_valid, mul_op_start, mul_op_clear}), 128'd0);
      checkOutput("mid_reset_id", 128'(rsp_id), 128'd0);
      checkOutput("mid_reset_operands", 128'({mul_multiplier, mul_multiplicand}), 128'd0);
      pend[1] = 0;
      ptr = 0;
      applyStimulus();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      $display("[TB] contention rotation");
      for (int i = 0; i < NUM_REQ; i++) begin
         pend[i] = 1; op_a[i] = rand_op(); op_b[i] = rand_op();
      end
      for (int t = 0; t < 5; t++) begin
         serve_one((t == 2) ? 10 : 0, 0, 1, 0);
         checkOutput("rotation_order", 128'(last_grant), 128'(rot[t]));
      end

      $display("[TB] randomized traffic");
      for (int t = 0; t < 40; t++) begin
         any = 0;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!pend[i] && $urandom_range(0, 1) == 1) begin
               pend[i] = 1; op_a[i] = rand_op(); op_b[i] = rand_op();
            end
            if (pend[i]) any = 1;
         end
         if (!any) begin
            int r;
            r = $urandom_range(0, NUM_REQ - 1);
            pend[r] = 1; op_a[r] = rand_op(); op_b[r] = rand_op();
         end
         serve_one($urandom_range(0, 4), $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, 1);
      end

`ifdef MUL_TIMEOUT_EN
      begin
         int  cycles;
         bit  got;
         $display("[TB] timeout abort");
         for (int i = 0; i < NUM_REQ; i++) pend[i] = 0;
         pend[3] = 1; op_a[3] = rand_op(); op_b[3] = rand_op();
         stub_mute = 1'b1;
         applyStimulus();
         got = 0;
         for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (req_ack != '0) got = 1;
         end
         checkOutput("to_ack", 128'(req_ack), 128'b1000);
         pend[3] = 0;
         applyStimulus();
         got = 0; cycles = 0;
         for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            cycles++;
            if (rsp_valid) got = 1;
         end
         checkOutput("to_cycles", 128'(cycles), 128'd65);
         checkOutput("to_err", 128'(rsp_err), 128'd1);
         checkOutput("to_result", rsp_result, 128'd0);
         checkOutput("to_clear", 128'(mul_op_clear), 128'd1);
         rsp_ready = 1'b1;
         @(negedge clk);
         checkOutput("to_released", 128'(rsp_valid), 128'd0);
         rsp_ready = 1'b0;
         stub_mute = 1'b0;
      end
`endif

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule
